// File: rtl/mux_defs_pkg.sv
// Shared definitions for the 2:1 mux select controller: FSM states, trigger modes
// and a terminal-index helper.
package mux_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GUARD  = 2'd2
  } state_t;

  localparam int unsigned MODE_AUTO = 0;
  localparam int unsigned MODE_REQ  = 1;

  // Last count index of an n-cycle phase; a zero-length phase maps to 0.
  function automatic int unsigned last_idx(input int unsigned n);
    return (n == 0) ? 0 : n - 1;
  endfunction

endpackage

// File: rtl/mux_sel_ctrl_cnt.sv
// Phase counter shared by dwell and guard timing: clear beats load beats increment,
// and at_term flags when the count equals the supplied terminal value.
module sel_phase_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cnt,
  output logic             at_term
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_term = (cnt == term);

endmodule

// File: rtl/mux_sel_ctrl.sv
// Control stage for the 2:1 mux family: registers a/b and drives a break-before-make
// select with a valid qualifier and a one-cycle ack on each toggle.
module mux_sel_ctrl
  import mux_defs::*;
#(
  parameter int unsigned MODE  = MODE_AUTO,
  parameter int unsigned DWELL = 8,
  parameter int unsigned GUARD = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic a,
  input  logic b,
  input  logic req,
  input  logic hold,
  output logic a_q,
  output logic b_q,
  output logic sel,
  output logic valid,
  output logic ack
);

  localparam logic [CNT_W-1:0] DWELL_TERM = CNT_W'(last_idx(DWELL));
  localparam logic [CNT_W-1:0] GUARD_TERM = CNT_W'(last_idx(GUARD));

  state_t           state, state_n;
  logic             sel_n, valid_n, ack_n;
  logic             cnt_clr, cnt_inc, at_term;
  logic             switch_start, dwell_inc;
  logic [CNT_W-1:0] cnt, term;

  assign term = (state == ST_GUARD) ? GUARD_TERM : DWELL_TERM;

  sel_phase_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (cnt_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (cnt_inc),
    .term     (term),
    .cnt      (cnt),
    .at_term  (at_term)
  );

  generate
    case (MODE)
      MODE_REQ: begin : g_req
        logic unused_in;
        assign unused_in    = ^{hold, cnt};
        assign switch_start = (state == ST_ACTIVE) && req;
        assign dwell_inc    = 1'b0;
      end
      default: begin : g_auto
        logic unused_in;
        assign unused_in    = ^{req, cnt};
        assign switch_start = (state == ST_ACTIVE) && !hold && at_term;
        assign dwell_inc    = !hold;
      end
    endcase
  endgenerate

  always_comb begin
    state_n = state;
    sel_n   = sel;
    ack_n   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    // en=0 dominates both a pending switch and guard completion.
    if (!en) begin
      state_n = ST_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_ACTIVE;
          cnt_clr = 1'b1;
        end
        ST_ACTIVE: begin
          if (switch_start) begin
            cnt_clr = 1'b1;
            if (GUARD == 0) begin
              sel_n = ~sel;
              ack_n = 1'b1;
            end else begin
              state_n = ST_GUARD;
            end
          end else begin
            cnt_inc = dwell_inc;
          end
        end
        ST_GUARD: begin
          if (at_term) begin
            sel_n   = ~sel;
            ack_n   = 1'b1;
            cnt_clr = 1'b1;
            state_n = ST_ACTIVE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
    valid_n = (state_n == ST_ACTIVE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      sel   <= 1'b0;
      valid <= 1'b0;
      ack   <= 1'b0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      valid <= valid_n;
      ack   <= ack_n;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q <= 1'b0;
      b_q <= 1'b0;
    end else begin
      a_q <= a;
      b_q <= b;
    end
  end

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Self-checking bench for mux_sel_ctrl: three configurations driven in parallel and
// compared each cycle against a phase-level behavioural model.
module tb_mux_sel_ctrl;
  import mux_defs::*;

  logic clk = 1'b0, rstn = 1'b0, en = 1'b0, a = 1'b0, b = 1'b0, req = 1'b0, hold = 1'b0;
  logic [2:0] a_q, b_q, sel, valid, ack;
  int n_tests = 0, n_fail = 0, cyc = 0;

  always #5 clk = ~clk;

  mux_sel_ctrl #(.MODE(MODE_AUTO), .DWELL(4), .GUARD(1), .CNT_W(8)) u0 (
    .clk(clk), .rstn(rstn), .en(en), .a(a), .b(b), .req(req), .hold(hold),
    .a_q(a_q[0]), .b_q(b_q[0]), .sel(sel[0]), .valid(valid[0]), .ack(ack[0]));
  mux_sel_ctrl #(.MODE(MODE_REQ), .DWELL(4), .GUARD(2), .CNT_W(8)) u1 (
    .clk(clk), .rstn(rstn), .en(en), .a(a), .b(b), .req(req), .hold(hold),
    .a_q(a_q[1]), .b_q(b_q[1]), .sel(sel[1]), .valid(valid[1]), .ack(ack[1]));
  mux_sel_ctrl #(.MODE(MODE_REQ), .DWELL(4), .GUARD(0), .CNT_W(4)) u2 (
    .clk(clk), .rstn(rstn), .en(en), .a(a), .b(b), .req(req), .hold(hold),
    .a_q(a_q[2]), .b_q(b_q[2]), .sel(sel[2]), .valid(valid[2]), .ack(ack[2]));

  // Reference model: "on" = select usable, guard_left = remaining blank cycles,
  // elapsed = non-held active cycles in the current dwell phase.
  int p_mode[3]  = '{0, 1, 1};
  int p_dwell[3] = '{4, 4, 4};
  int p_guard[3] = '{1, 2, 0};
  bit m_on[3], m_sel[3], m_ack[3], m_aq[3], m_bq[3];
  int m_gl[3], m_el[3];

  always @(posedge clk or negedge rstn) begin
    for (int i = 0; i < 3; i++) begin
      if (!rstn) begin
        m_on[i] = 0; m_sel[i] = 0; m_ack[i] = 0; m_aq[i] = 0; m_bq[i] = 0;
        m_gl[i] = 0; m_el[i] = 0;
      end else begin
        bit trig;
        m_aq[i] = a; m_bq[i] = b; m_ack[i] = 0; trig = 0;
        if (!en) begin
          m_on[i] = 0; m_gl[i] = 0; m_el[i] = 0;
        end else if (m_gl[i] > 0) begin
          m_gl[i]--;
          if (m_gl[i] == 0) begin
            m_sel[i] = !m_sel[i]; m_ack[i] = 1; m_on[i] = 1; m_el[i] = 0;
          end
        end else if (!m_on[i]) begin
          m_on[i] = 1; m_el[i] = 0;
        end else begin
          if (p_mode[i] == 0) begin
            if (!hold) begin
              m_el[i]++;
              if (m_el[i] == p_dwell[i]) begin trig = 1; m_el[i] = 0; end
            end
          end else begin
            trig = req;
          end
          if (trig) begin
            if (p_guard[i] == 0) begin m_sel[i] = !m_sel[i]; m_ack[i] = 1; end
            else begin m_on[i] = 0; m_gl[i] = p_guard[i]; end
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 3; i++)
      chk($sformatf("u%0d_out", i), {27'b0, a_q[i], b_q[i], sel[i], valid[i], ack[i]},
          {27'b0, m_aq[i], m_bq[i], m_sel[i], m_on[i], m_ack[i]});
  endtask

  // Assert reset between clock edges and check outputs clear without a clock.
  task automatic async_rst();
    #2 rstn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("u%0d_rst_zero", i), {27'b0, a_q[i], b_q[i], sel[i], valid[i], ack[i]}, 0);
    #1 rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [11:0] v_rec, s_rec, k_rec;
    logic [9:0]  r_ack, r_val;
    logic [3:0]  h_ack, h_val;
    int first_ack, w;

    a = 1'b1; b = 1'b1;
    tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("u%0d_init_zero", i), {27'b0, a_q[i], b_q[i], sel[i], valid[i], ack[i]}, 0);
    rstn = 1'b1; a = 1'b0; b = 1'b0;
    tick();
    chk("idle_valid", {29'b0, valid}, 0);

    en = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick();
      v_rec[t] = valid[0]; s_rec[t] = sel[0]; k_rec[t] = ack[0];
    end
    chk("u0_valid_pat", {20'b0, v_rec}, 32'hDEF);
    chk("u0_sel_pat",   {20'b0, s_rec}, 32'h3E0);
    chk("u0_ack_pat",   {20'b0, k_rec}, 32'h420);

    first_ack = -1;
    for (int t = 13; t <= 22; t++) begin
      hold = ((t >= 14) && (t <= 16)) || (t == 19);
      tick();
      if (ack[0] && first_ack < 0) first_ack = t;
    end
    hold = 1'b0;
    chk("u0_hold_delay", first_ack, 19);

    for (int r = 0; r < 10; r++) begin
      req = (r == 0) || (r == 5) || (r == 6);
      tick();
      r_ack[r] = ack[1]; r_val[r] = valid[1];
    end
    req = 1'b0;
    chk("u1_req_ack", {22'b0, r_ack}, 32'h084);
    chk("u1_req_valid", {22'b0, r_val}, 32'h39C);

    for (int r = 0; r < 4; r++) begin
      req = (r < 3);
      tick();
      h_ack[r] = ack[2]; h_val[r] = valid[2];
    end
    req = 1'b0;
    chk("u2_held_ack", {28'b0, h_ack}, 32'h7);
    chk("u2_held_valid", {28'b0, h_val}, 32'hF);

    repeat (4) tick();
    req = 1'b1;
    tick();
    chk("u1_guard_entry", {31'b0, valid[1]}, 0);
    req = 1'b0; en = 1'b0; a = 1'b1; b = 1'b0;
    tick();
    chk("u1_abort_ack", {31'b0, ack[1]}, 0);
    chk("u1_abort_valid", {31'b0, valid[1]}, 0);
    chk("aq_en_off", {29'b0, a_q}, 32'h7);
    chk("bq_en_off", {29'b0, b_q}, 32'h0);
    tick();
    chk("u1_abort_ack2", {31'b0, ack[1]}, 0);
    en = 1'b1;

    for (int n = 0; n < 1500; n++) begin
      en   = ($urandom_range(0, 15) != 0);
      a    = 1'($urandom);
      b    = 1'($urandom);
      req  = ($urandom_range(0, 3) == 0);
      hold = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) async_rst();
      tick();
    end

    en = 1'b1; req = 1'b0; hold = 1'b0;
    w = 0;
    while (!m_sel[0] && w < 50) begin
      tick();
      w++;
    end
    chk("wait_budget", {31'b0, (w < 50)}, 1);
    chk("u0_sel_before_rst", {31'b0, sel[0]}, 1);
    async_rst();
    tick();
    chk("post_rst_valid", {29'b0, valid}, 32'h7);
    chk("post_rst_sel", {29'b0, sel}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_sel_ctrl.md
Name: mux_sel_ctrl

Overview:
- Upstream control stage for the 2:1 mux family (assign- and case-style muxes).
- Registers the two data inputs and generates a break-before-make `sel` with a `valid` qualifier.
- Select switching is either time-division (dwell counter) or request/ack driven, chosen by a parameter through a generate case.
- Outputs `a_q`, `b_q` and `sel` connect directly to the a/b/sel inputs of the downstream mux.

Parameters:
- MODE, 0, switch trigger: 0 = auto-alternate every DWELL cycles; 1 = switch on `req`.
- DWELL, 8, active cycles per select phase in MODE 0 (legal range 1..2^CNT_W-1).
- GUARD, 1, `valid`-low gap cycles inserted before each `sel` toggle (legal range 0..2^CNT_W-1).
- CNT_W, 8, width of the shared phase counter.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  block enable.
- a  in  1  data input A.
- b  in  1  data input B.
- req  in  1  switch request (used in MODE 1 only).
- hold  in  1  freeze the dwell counter (used in MODE 0 only).
- a_q  out  1  registered a, to the mux a input.
- b_q  out  1  registered b, to the mux b input.
- sel  out  1  mux select, registered.
- valid  out  1  high when `sel` is stable and the mux output may be consumed.
- ack  out  1  one-cycle pulse in the cycle `sel` takes its new value.

Behaviour:
- Reset (rstn=0, asynchronous, takes effect mid-operation):
  - state=IDLE, cnt=0.
  - sel=0, valid=0, ack=0, a_q=0, b_q=0.
- Data path: a_q<=a and b_q<=b every cycle, independent of state and en. Latency is 1 cycle.
- States: IDLE, ACTIVE, GUARD.
- IDLE:
  - valid=0, sel holds its value.
  - en=1 -> ACTIVE next cycle with valid=1 and cnt=0.
- ACTIVE, MODE 0:
  - cnt increments each cycle while hold=0; hold=1 freezes cnt.
  - When cnt==DWELL-1 and hold=0: cnt clears and the switch starts.
- ACTIVE, MODE 1:
  - cnt is unused (kept at 0).
  - req=1 sampled in ACTIVE starts the switch.
  - req is level-sampled; holding it high gives back-to-back switches, each separated by GUARD.
- Switch start, GUARD>0:
  - Go to GUARD with valid=0 from the next cycle; sel is unchanged.
- Switch start, GUARD=0:
  - sel toggles on the next edge, valid stays 1, ack=1 for that cycle, state stays ACTIVE.
- GUARD:
  - valid=0; cnt counts from 0.
  - When cnt==GUARD-1: sel<=~sel, ack<=1, valid<=1, cnt<=0, state<=ACTIVE.
  - hold and req are ignored.
- ack: one cycle only, aligned with the first cycle of the new sel. Never asserted outside a toggle.
- en=0 in any state -> IDLE next cycle, valid=0, cnt=0.
  - If this aborts a GUARD, sel is not toggled and ack is not pulsed.
- Simultaneous events:
  - en=0 wins over a switch start and over GUARD completion.
  - req in IDLE or GUARD is dropped, not queued.
- Invariant: sel changes only on a cycle where the previous cycle had valid=0 (when GUARD>0).

Decomposition:
- Shared package/header mux_defs:
  - state encodings ST_IDLE=2'd0, ST_ACTIVE=2'd1, ST_GUARD=2'd2.
  - mode constants MODE_AUTO=0, MODE_REQ=1.
- One sub-module, sel_phase_cnt: loadable/clearable CNT_W counter with enable and a terminal-compare output, used for both dwell and guard counting.
- Top-level generate case (MODE) selects the switch-trigger logic: dwell terminal count vs req.

Test Plan:
- Reset/enable: rstn=0 mid-run with sel=1 -> sel=0, valid=0, ack=0 immediately. Then en=1 -> valid=1 one cycle later, sel=0.
- MODE 0, DWELL=4, GUARD=1, hold=0 -> valid high 4 cycles, low 1 cycle, then sel=1 with ack pulse. Pattern repeats; sel period 10 cycles.
- MODE 0 hold: assert hold for 3 cycles at cnt=2 (DWELL=4) -> toggle delayed by exactly 3 cycles. hold asserted during GUARD has no effect.
- MODE 1, GUARD=2: single req pulse in ACTIVE -> valid low 2 cycles, sel toggles, ack one cycle. req pulse during GUARD -> ignored, no second toggle.
- GUARD=0, MODE 1, req held high 3 cycles -> sel toggles each cycle, valid stays 1, ack high 3 cycles.
- Abort: en=0 in the first GUARD cycle -> IDLE, sel unchanged, no ack. a=1/b=0 driven -> a_q=1, b_q=0 one cycle later regardless of en.
